rah_divider_app: RTL

RAH_DIVIDER_APP -- requirements
Module: rah_divider_app

---
 rtl/rah_divider_app_pkg.sv | 32 +++
 rtl/rah_divider_app_divu.sv | 57 +++++
 rtl/rah_divider_app.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/rah_divider_app_pkg.sv
// Shared definitions for the RAH divider: FSM encodings, header and status
// bit positions in the 48-bit RAH packet, and the captured-header record.
package rah_divider_app_pkg;

    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] ST_IDLE  = 4'd0;
    localparam logic [STATE_W-1:0] ST_LD_A  = 4'd1;
    localparam logic [STATE_W-1:0] ST_REQ_B = 4'd2;
    localparam logic [STATE_W-1:0] ST_LD_B  = 4'd3;
    localparam logic [STATE_W-1:0] ST_CHECK = 4'd4;
    localparam logic [STATE_W-1:0] ST_DIV   = 4'd5;
    localparam logic [STATE_W-1:0] ST_FIX   = 4'd6;
    localparam logic [STATE_W-1:0] ST_WR_Q  = 4'd7;
    localparam logic [STATE_W-1:0] ST_WR_R  = 4'd8;

    // Header fields (dividend request and both responses)
    localparam int HDR_SIGNED_BIT = 47;
    localparam int HDR_TAG_HI     = 46;
    localparam int HDR_TAG_LO     = 40;
    localparam int TAG_W          = HDR_TAG_HI - HDR_TAG_LO + 1;

    // Status flags (responses only)
    localparam int STAT_OVF_BIT   = 39;
    localparam int STAT_DBZ_BIT   = 38;

    typedef struct packed {
        logic             sgn;
        logic [TAG_W-1:0] tag;
    } req_hdr_t;

endpackage

// File: rtl/rah_divider_app_divu.sv
// Unsigned restoring divider: one shift-subtract step per clock, DATA_W
// steps after a start pulse. done marks the cycle of the final step so the
// parent can leave its DIV state with results valid on the next cycle.
module divu_iter
    import rah_divider_app_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] den;
    logic [DATA_W:0]   trial;
    logic [DATA_W:0]   diff;

    // Trial subtraction; diff MSB is the borrow (trial < divisor)
    always_comb begin
        trial = {rem, quo[DATA_W-1]};
        diff  = trial - {1'b0, den};
    end

    // Load operands on start, then step until the down-counter hits zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            quo <= '0;
            rem <= '0;
            den <= '0;
        end else if (start) begin
            cnt <= CNT_W'(DATA_W);
            quo <= dividend;
            rem <= '0;
            den <= divisor;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
            quo <= {quo[DATA_W-2:0], ~diff[DATA_W]};
            rem <= diff[DATA_W] ? trial[DATA_W-1:0] : diff[DATA_W-1:0];
        end
    end

    assign done      = (cnt == CNT_W'(1));
    assign quotient  = quo;
    assign remainder = rem;

endmodule

// File: rtl/rah_divider_app.sv
// RAH divider application: pops a dividend/divisor packet pair from the read
// queue, divides (unsigned or signed, truncating toward zero) and pushes a
// quotient packet followed by a remainder packet to the encoder queue.
//
//   state  | meaning
//   IDLE   | waiting for a request; pops the dividend when queue non-empty
//   LD_A   | dividend packet on data; capture operand, sign, tag
//   REQ_B  | waiting for divisor; pops it when queue non-empty
//   LD_B   | divisor packet on data; capture operand
//   CHECK  | divide-by-zero / signed overflow shortcut, else start divider
//   DIV    | iterative divider running, DATA_W cycles
//   FIX    | apply quotient and remainder signs
//   WR_Q   | present quotient packet, push when encoder not full
//   WR_R   | present remainder packet, push when encoder not full
module rah_divider_app
    import rah_divider_app_pkg::*;
#(
    parameter int PKT_W  = 48,
    parameter int DATA_W = 32,
    parameter int MODE   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PKT_W-1:0] data,
    input  logic             empty,
    input  logic             almost_empty,
    output logic             RD_en,
    input  logic             wr_full,
    output logic             wr_en,
    output logic [PKT_W-1:0] wr_data,
    output logic             busy
);

    logic [STATE_W-1:0] state;
    logic [DATA_W-1:0]  a_reg;
    logic [DATA_W-1:0]  b_reg;
    req_hdr_t           hdr;
    logic               ovf;
    logic               dbz;
    logic [DATA_W-1:0]  q_res;
    logic [DATA_W-1:0]  r_res;

    logic               neg_a;
    logic               neg_b;
    logic               is_dbz;
    logic               is_ovf;
    logic [DATA_W-1:0]  mag_a;
    logic [DATA_W-1:0]  mag_b;
    logic               div_start;
    logic               div_done;
    logic [DATA_W-1:0]  uq;
    logic [DATA_W-1:0]  ur;
    logic               eff_sgn;
    logic [DATA_W-1:0]  res;

    // Header bits beyond the operand and the divisor header are don't-care
    logic unused_in;
    assign unused_in = ^{data, almost_empty};

    // Effective signedness of the incoming dividend packet
    always_comb begin
        case (MODE)
            0:       eff_sgn = 1'b0;
            1:       eff_sgn = 1'b1;
            default: eff_sgn = data[HDR_SIGNED_BIT];
        endcase
    end

    // Operand sign analysis and magnitudes for the unsigned core
    always_comb begin
        neg_a     = hdr.sgn & a_reg[DATA_W-1];
        neg_b     = hdr.sgn & b_reg[DATA_W-1];
        mag_a     = neg_a ? -a_reg : a_reg;
        mag_b     = neg_b ? -b_reg : b_reg;
        is_dbz    = (b_reg == '0);
        is_ovf    = hdr.sgn && (a_reg == {1'b1, {(DATA_W-1){1'b0}}}) && (b_reg == '1);
        div_start = (state == ST_CHECK) && !is_dbz && !is_ovf;
    end

    divu_iter #(
        .DATA_W (DATA_W)
    ) u_divu (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quotient  (uq),
        .remainder (ur),
        .done      (div_done)
    );

    // Request sequencing and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            a_reg <= '0;
            b_reg <= '0;
            hdr   <= '0;
            ovf   <= 1'b0;
            dbz   <= 1'b0;
            q_res <= '0;
            r_res <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty) state <= ST_LD_A;
                end
                ST_LD_A: begin
                    a_reg   <= data[DATA_W-1:0];
                    hdr.sgn <= eff_sgn;
                    hdr.tag <= data[HDR_TAG_HI:HDR_TAG_LO];
                    state   <= ST_REQ_B;
                end
                ST_REQ_B: begin
                    if (!empty) state <= ST_LD_B;
                end
                ST_LD_B: begin
                    b_reg <= data[DATA_W-1:0];
                    state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (is_dbz) begin
                        q_res <= '1;
                        r_res <= a_reg;
                        dbz   <= 1'b1;
                        ovf   <= 1'b0;
                        state <= ST_WR_Q;
                    end else if (is_ovf) begin
                        q_res <= a_reg;
                        r_res <= '0;
                        dbz   <= 1'b0;
                        ovf   <= 1'b1;
                        state <= ST_WR_Q;
                    end else begin
                        dbz   <= 1'b0;
                        ovf   <= 1'b0;
                        state <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    if (div_done) state <= ST_FIX;
                end
                ST_FIX: begin
                    q_res <= (neg_a ^ neg_b) ? -uq : uq;
                    r_res <= neg_a ? -ur : ur;
                    state <= ST_WR_Q;
                end
                ST_WR_Q: begin
                    if (!wr_full) state <= ST_WR_R;
                end
                ST_WR_R: begin
                    if (!wr_full) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Queue handshakes; rst gates RD_en so reset never pops the queue
    always_comb begin
        RD_en = !rst && !empty && ((state == ST_IDLE) || (state == ST_REQ_B));
        wr_en = !wr_full && ((state == ST_WR_Q) || (state == ST_WR_R));
        busy  = (state != ST_IDLE);
    end

    // Response packet, held for the whole write state and zero elsewhere
    always_comb begin
        wr_data = '0;
        res     = (state == ST_WR_Q) ? q_res : r_res;
        if ((state == ST_WR_Q) || (state == ST_WR_R)) begin
            wr_data[HDR_SIGNED_BIT]         = hdr.sgn;
            wr_data[HDR_TAG_HI:HDR_TAG_LO]  = hdr.tag;
            wr_data[STAT_OVF_BIT]           = ovf;
            wr_data[STAT_DBZ_BIT]           = dbz;
            wr_data[DATA_W-1:0]             = res;
        end
    end

endmodule
